// File: rtl/req_arbiter8_if.sv
// Request/grant bundle between up to eight requesters and the shared-port arbiter.
// The master drives requests and enable, and the slave (arbiter) returns the registered grant.
interface req_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/req_arbiter8.sv
// Eight-way arbiter for one shared datapath port with hold-time limit, one-cycle release gap
// and MSB-first priority. Define ROUND_ROBIN_EN to rotate priority after every grant.
module req_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    req_arbiter8_if.slave  bus
);

    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    genvar gi;

    logic [1:0]       state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mask_q, mask_d;

    logic [7:0]       cand;
    logic             win_found;
    logic [2:0]       win_idx;
    logic [7:0]       win_onehot;
    logic             load_grant;

    // Mask is only ever non-zero in GAP, so IDLE effectively sees all requests.
    assign cand = bus.req & ~mask_q;

`ifdef ROUND_ROBIN_EN
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] cand_ord;

    // cand_ord[0] is the highest-priority slot, (ptr-1) mod 8, descending with wrap.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign cand_ord[gi] = cand[rr_ptr_q - 3'd1 - 3'(gi)];
        end
    endgenerate

    always_comb begin
        win_found = |cand;
        win_idx   = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (cand_ord[j]) begin
                win_idx = rr_ptr_q - 3'd1 - 3'(j);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load_grant) begin
            rr_ptr_d = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 3'd7;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        win_found = |cand;
        win_idx   = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (cand[j]) begin
                win_idx = 3'(j);
            end
        end
    end
`endif

    generate
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        load_grant  = 1'b0;

        case (state_q)
            ST_GRANT: begin
                if (!bus.en || !bus.req[gnt_idx_q]) begin
                    // Voluntary release or disable: never reported as a timeout.
                    state_d     = ST_GAP;
                    gnt_d       = 8'd0;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LIMIT)) begin
                    state_d     = ST_GAP;
                    gnt_d       = 8'd0;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    timeout_d   = 1'b1;
                    mask_d      = gnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE, ST_GAP: begin
                mask_d = 8'd0;
                cnt_d  = '0;
                if (bus.en && win_found) begin
                    load_grant  = 1'b1;
                    state_d     = ST_GRANT;
                    gnt_d       = win_onehot;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = 8'd0;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 8'd0;
                gnt_idx_d   = 3'd0;
                gnt_valid_d = 1'b0;
                cnt_d       = '0;
                mask_d      = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            mask_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard bench for req_arbiter8: directed scenarios plus random request traffic, each cycle
// checked against an ownership-level reference model (fixed or ROUND_ROBIN_EN priority).
module tb_req_arbiter8;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    req_arbiter8_if bus();

    req_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       tout;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   tout_cnt = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model: who owns the port, for how long, and who is barred from the next pick.
    int m_owner = -1;
    int m_held  = 0;
    int m_mask  = -1;
    int m_ptr   = 7;

    function automatic int pick(input logic [7:0] r, input int mask);
`ifdef ROUND_ROBIN_EN
        for (int j = 1; j <= 8; j++) begin
            int i;
            i = (m_ptr - j + 16) % 8;
            if (r[i] && i != mask) return i;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (r[i] && i != mask) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_mask  = -1;
        m_ptr   = 7;
        exp_q.delete();
    endtask

    task automatic apply(input logic [7:0] r, input logic e);
        exp_t x;
        int   w;
        logic t;
        bus.req = r;
        bus.en  = e;
        t = 1'b0;
        if (m_owner >= 0) begin
            if (!e || !r[m_owner]) begin
                m_owner = -1;
                m_held  = 0;
                m_mask  = -1;
            end else if (MH != 0 && m_held == MH) begin
                m_mask  = m_owner;
                m_owner = -1;
                m_held  = 0;
                t = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            w = e ? pick(r, m_mask) : -1;
            m_mask = -1;
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_ptr   = w;
            end
        end
        x.gnt   = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        x.idx   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        x.valid = (m_owner >= 0);
        x.tout  = t;
        exp_q.push_back(x);
    endtask

    task automatic cycle(input logic [7:0] r, input logic e);
        @(negedge clk);
        apply(r, e);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_gnt"},       int'(bus.gnt),       0);
        check_val({tag, "_gnt_idx"},   int'(bus.gnt_idx),   0);
        check_val({tag, "_gnt_valid"}, int'(bus.gnt_valid), 0);
        check_val({tag, "_timeout"},   int'(bus.timeout),   0);
    endtask

    // Asserts reset between clock edges so the asynchronous clear is observable at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h00, 1'b0);
        starts.delete();
        tout_cnt = 0;
    endtask

    // Monitor: one scoreboard comparison per clock, plus a log line per new grant.
    exp_t mon_e;
    logic prev_valid = 1'b0;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests_run++;
            if (bus.gnt !== mon_e.gnt || bus.gnt_idx !== mon_e.idx ||
                bus.gnt_valid !== mon_e.valid || bus.timeout !== mon_e.tout) begin
                tests_failed++;
                $display("FAIL cycle t=%0t: got gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
                         $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
                         mon_e.gnt, mon_e.idx, mon_e.valid, mon_e.tout);
            end
        end
        if (bus.gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
            starts.push_back(int'(bus.gnt_idx));
            $display("[TB] t=%0t grant idx=%0d req=%b en=%b", $time, bus.gnt_idx, bus.req, bus.en);
        end
        if (bus.timeout === 1'b1) tout_cnt++;
        prev_valid = bus.gnt_valid;
    end

    int         exp3[3];
    int         exp5[9];
    logic [7:0] cur_req;
    logic       cur_en;

    initial begin
        bus.req = 8'h00;
        bus.en  = 1'b0;
`ifdef ROUND_ROBIN_EN
        exp3 = '{3, 7, 3};
        exp5 = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
`else
        exp3 = '{7, 3, 7};
        exp5 = '{7, 6, 7, 6, 7, 6, 7, 6, 7};
`endif

        // Power-on reset state.
        @(negedge clk);
        check_outputs_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h00, 1'b0);

        // Basic pick plus release with a one-cycle gap.
        do_reset("rst_a");
        repeat (3) cycle(8'b0010_0100, 1'b1);
        repeat (4) cycle(8'b0000_0100, 1'b1);
        cycle(8'h00, 1'b1);
        check_val("release_grants", starts.size(), 2);
        if (starts.size() >= 2) begin
            check_val("release_first", starts[0], 5);
            check_val("release_second", starts[1], 2);
        end

        // Hold-limit expiry with constant contention.
        do_reset("rst_b");
        repeat (13) cycle(8'h88, 1'b1);
        cycle(8'h00, 1'b1);
        check_val("timeout_pulses", tout_cnt, 2);
        check_val("timeout_grants", starts.size(), 3);
        for (int i = 0; i < 3 && i < starts.size(); i++) check_val("timeout_order", starts[i], exp3[i]);

        // Enable dropped during the third grant cycle.
        do_reset("rst_c");
        repeat (3) cycle(8'h40, 1'b1);
        repeat (4) cycle(8'h40, 1'b0);
        repeat (3) cycle(8'h01, 1'b1);
        cycle(8'h00, 1'b1);
        check_val("en_drop_timeouts", tout_cnt, 0);
        check_val("en_drop_grants", starts.size(), 2);
        if (starts.size() >= 2) begin
            check_val("en_drop_first", starts[0], 6);
            check_val("en_drop_second", starts[1], 0);
        end

        // All requesting: order shows mask effect or rotation.
        do_reset("rst_d");
        repeat (43) cycle(8'hFF, 1'b1);
        cycle(8'h00, 1'b1);
        check_val("all_req_grants_min", int'(starts.size() >= 9), 1);
        for (int i = 0; i < 9 && i < starts.size(); i++) check_val("all_req_order", starts[i], exp5[i]);

        // Asynchronous reset in the middle of a grant, then a fresh grant.
        do_reset("rst_e");
        repeat (3) cycle(8'h10, 1'b1);
        check_val("pre_rst_valid", int'(bus.gnt_valid), 1);
        do_reset("mid_grant_rst");
        cycle(8'h10, 1'b1);
        cycle(8'h10, 1'b1);
        check_val("post_rst_idx", int'(bus.gnt_idx), 4);
        check_val("post_rst_valid", int'(bus.gnt_valid), 1);
        cycle(8'h00, 1'b1);

        // Random traffic.
        do_reset("rst_f");
        cur_req = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) cur_req = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) cur_req[$urandom_range(0, 7)] = ~cur_req[$urandom_range(0, 7)];
            cur_en = ($urandom_range(0, 19) != 0);
            cycle(cur_req, cur_en);
        end
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        @(posedge clk);
        #2;
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
